// File: rtl/disp_scan_mux_pkg.sv
// Shared constants and width helpers for the display scan multiplexer.
package disp_scan_mux_pkg;

    localparam logic DP_OFF = 1'b1;

    // Index/counter width that stays at least one bit wide for a range of one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_mux_scan_prescaler.sv
// Slot counter: counts 0..DIV-1 and flags slot end and the blanking window.
module scan_prescaler
    import disp_scan_mux_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = idx_w(DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign slot_end = en && (cnt == CW'(DIV - 1));

    always_comb begin
        cnt_nxt = cnt;
        if (slot_end) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Phase of the count being loaded, so registered outputs line up with cnt.
    assign in_blank = (cnt_nxt < CW'(BLANK));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexes NDIG hex digits onto one 7448 decoder bus with per-slot
// blanking, frame snapshots and optional leading-zero suppression.
module disp_scan_mux
    import disp_scan_mux_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              upd,
    input  logic              lzb,
    output logic [3:0]        Z,
    output logic [NDIG-1:0]   an,
    output logic              dp,
    output logic              frame_tick
);

    localparam int              IDXW   = idx_w(NDIG);
    localparam logic [NDIG-1:0] AN_OFF = '1;

    logic              run;
    logic              slot_end;
    logic              in_blank;
    logic              wrap;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_nxt;
    logic [4*NDIG-1:0] snap;
    logic [4*NDIG-1:0] snap_nxt;
    logic [NDIG-1:0]   dps;
    logic [NDIG-1:0]   dps_nxt;
    logic [NDIG-1:0]   supp;
    logic              show;
    logic [3:0]        z_nxt;
    logic [NDIG-1:0]   an_nxt;
    logic              dp_nxt;

    // The counter holds for the first clock after reset so the scan starts at cnt 0.
    scan_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (run),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    assign wrap = slot_end && (idx == IDXW'(NDIG - 1));

    always_comb begin
        idx_nxt = idx;
        if (wrap) begin
            idx_nxt = '0;
        end else if (slot_end) begin
            idx_nxt = idx + IDXW'(1);
        end
    end

    assign snap_nxt = (wrap && upd) ? digits : snap;
    assign dps_nxt  = (wrap && upd) ? dp_in  : dps;

    // Digit i is blanked when it and every higher snapshot digit are zero.
    always_comb begin
        supp = '0;
        for (int i = 1; i < NDIG; i++) begin
            supp[i] = lzb;
            for (int j = i; j < NDIG; j++) begin
                if (snap_nxt[4*j +: 4] != 4'h0) begin
                    supp[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        show   = !in_blank && !supp[idx_nxt];
        z_nxt  = snap_nxt[4*idx_nxt +: 4];
        an_nxt = AN_OFF;
        dp_nxt = DP_OFF;
        if (show) begin
            an_nxt[idx_nxt] = 1'b0;
            dp_nxt          = ~dps_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= 1'b0;
            idx        <= '0;
            snap       <= digits;
            dps        <= dp_in;
            Z          <= 4'h0;
            an         <= AN_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            run        <= 1'b1;
            idx        <= idx_nxt;
            snap       <= snap_nxt;
            dps        <= dps_nxt;
            Z          <= z_nxt;
            an         <= an_nxt;
            dp         <= dp_nxt;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed self-checking bench for disp_scan_mux with NDIG=4, DIV=8, BLANK=2.
module tb_disp_scan_mux;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        upd;
    logic        lzb;
    logic [3:0]  Z;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    disp_scan_mux #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .upd        (upd),
        .lzb        (lzb),
        .Z          (Z),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {Z, an, dp} at frame cycle c for snapshot s, dp snapshot d.
    function automatic logic [8:0] exp_out(input int c, input logic [15:0] s,
                                           input logic [3:0] d, input logic lz);
        int          i;
        int          k;
        logic [15:0] hi;
        logic [3:0]  a;
        logic        shown;
        i     = (c / DIV) % NDIG;
        k     = c % DIV;
        hi    = s >> (4 * i);
        shown = (k >= BLANK) && !(lz && (i >= 1) && (hi == 16'h0));
        a     = 4'hF;
        if (shown) a[i] = 1'b0;
        return {hi[3:0], a, shown ? ~d[i] : 1'b1};
    endfunction

    // Leaves the DUT in frame cycle 0 with the given snapshot.
    task automatic apply_reset(input logic [15:0] dg, input logic [3:0] dpv);
        rst    = 1'b1;
        digits = dg;
        dp_in  = dpv;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        upd    = 1'b1;
        lzb    = 1'b0;
        digits = 16'h1234;
        dp_in  = 4'h0;
        for (int n = 0; n < 3; n++) begin
            step();
            n_cmp++;
            if ({Z, an, dp, frame_tick} !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset n=%0d got %h exp %h", n, {Z, an, dp, frame_tick},
                         {4'h0, 4'hF, 1'b1, 1'b0});
            end
        end
        rst = 1'b0;
    endtask

    // Frame 0 shows 1234 although digits change at cycle 12; frame 1 shows 5678.
    task automatic test_scan_snapshot();
        logic [8:0] e;
        step();
        for (int c = 0; c < 64; c++) begin
            e = exp_out(c, (c < 32) ? 16'h1234 : 16'h5678, 4'h0, 1'b0);
            n_cmp++;
            if ({Z, an, dp, frame_tick} !== {e, (c == 32)}) begin
                n_fail++;
                $display("FAIL scan c=%0d got %h exp %h", c, {Z, an, dp, frame_tick},
                         {e, (c == 32)});
            end
            if (c == 11) digits = 16'h5678;
            step();
        end
    endtask

    task automatic test_freeze();
        logic [8:0] e;
        upd = 1'b0;
        lzb = 1'b0;
        apply_reset(16'h5678, 4'h0);
        for (int c = 0; c < 64; c++) begin
            e = exp_out(c, 16'h5678, 4'h0, 1'b0);
            n_cmp++;
            if ({Z, an, dp, frame_tick} !== {e, (c == 32)}) begin
                n_fail++;
                $display("FAIL freeze c=%0d got %h exp %h", c, {Z, an, dp, frame_tick},
                         {e, (c == 32)});
            end
            if (c == 3) digits = 16'h9ABC;
            step();
        end
        upd = 1'b1;
    endtask

    task automatic test_lzb();
        logic [8:0] e;
        lzb = 1'b1;
        apply_reset(16'h0070, 4'h0);
        for (int c = 0; c < 64; c++) begin
            e = exp_out(c, (c < 32) ? 16'h0070 : 16'h0000, 4'h0, 1'b1);
            n_cmp++;
            if ({Z, an, dp, frame_tick} !== {e, (c == 32)}) begin
                n_fail++;
                $display("FAIL lzb c=%0d got %h exp %h", c, {Z, an, dp, frame_tick},
                         {e, (c == 32)});
            end
            if (c == 31) digits = 16'h0000;
            step();
        end
        lzb = 1'b0;
    endtask

    task automatic test_dp();
        logic exp_dp;
        apply_reset(16'h1234, 4'b0100);
        for (int c = 0; c < 32; c++) begin
            exp_dp = !((c >= 18) && (c <= 23));
            n_cmp++;
            if (dp !== exp_dp) begin
                n_fail++;
                $display("FAIL dp c=%0d got %b exp %b", c, dp, exp_dp);
            end
            step();
        end
        dp_in = 4'h0;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        apply_reset(16'h1234, 4'h0);
        for (int c = 0; c < 21; c++) step();
        e = exp_out(21, 16'h1234, 4'h0, 1'b0);
        n_cmp++;
        if ({Z, an, dp, frame_tick} !== {e, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_pre got %h exp %h", {Z, an, dp, frame_tick}, {e, 1'b0});
        end
        rst    = 1'b1;
        digits = 16'hABCD;
        step();
        n_cmp++;
        if ({Z, an, dp, frame_tick} !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got %h exp %h", {Z, an, dp, frame_tick},
                     {4'h0, 4'hF, 1'b1, 1'b0});
        end
        rst = 1'b0;
        step();
        for (int c = 0; c < 41; c++) begin
            e = exp_out(c, 16'hABCD, 4'h0, 1'b0);
            n_cmp++;
            if ({Z, an, dp, frame_tick} !== {e, (c == 32)}) begin
                n_fail++;
                $display("FAIL mid_resume c=%0d got %h exp %h", c, {Z, an, dp, frame_tick},
                         {e, (c == 32)});
            end
            step();
        end
    endtask

    initial begin
        rst    = 1'b1;
        upd    = 1'b1;
        lzb    = 1'b0;
        digits = 16'h0;
        dp_in  = 4'h0;
        test_reset();
        test_scan_snapshot();
        test_freeze();
        test_lzb();
        test_dp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
